// File: rtl/downcounter_8bit.sv
// Loadable down counter/timer with a one-cycle terminal-count pulse.
// It stops at zero in one-shot mode, or reloads the last loaded value in periodic mode.
module downcounter_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] Qout,
  output logic             zero,
  output logic             tc,
  output logic             busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;

  // Priority is load, then an enabled count step while running, then hold.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (load) begin
      count_d  = load_val;
      reload_d = load_val;
      state_d  = (load_val != '0) ? RUN : IDLE;
    end else if (state_q == RUN && en) begin
      if (count_q > WIDTH'(1)) begin
        count_d = count_q - WIDTH'(1);
      end else if (count_q == WIDTH'(1)) begin
        count_d = '0;
        tc_d    = 1'b1;
        if (!auto_reload) state_d = IDLE;
      end else if (auto_reload) begin
        count_d = reload_q;
      end else begin
        // Periodic mode was dropped while parked at zero, so park in IDLE.
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  assign Qout = count_q;
  assign zero = (count_q == '0);
  assign tc   = tc_q;
  assign busy = (state_q == RUN);

endmodule

// File: tb/tb_downcounter_8bit.sv
// Directed testbench for downcounter_8bit.
// Expected outputs are queued as each step is driven, then popped and checked after the edge.
module tb_downcounter_8bit;

  logic       clk;
  logic       reset;
  logic       load;
  logic [7:0] load_val;
  logic       en;
  logic       auto_reload;
  logic [7:0] Qout;
  logic       zero;
  logic       tc;
  logic       busy;

  typedef struct {
    logic [7:0] q;
    logic       tc;
    logic       busy;
    logic       zero;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  downcounter_8bit #(.WIDTH(8)) dut (
    .clk(clk),
    .reset(reset),
    .load(load),
    .load_val(load_val),
    .en(en),
    .auto_reload(auto_reload),
    .Qout(Qout),
    .zero(zero),
    .tc(tc),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pushExpected(input logic [7:0] q, input logic t, input logic b, input string tag);
    exp_t e;
    e.q    = q;
    e.tc   = t;
    e.busy = b;
    e.zero = (q == 8'd0);
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard_empty got 0 entries exp 1");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      assert (Qout === e.q) else begin
        errors++;
        $error("[TB] FAIL %s Qout got %0d exp %0d", e.tag, Qout, e.q);
      end
      checks++;
      assert (tc === e.tc) else begin
        errors++;
        $error("[TB] FAIL %s tc got %b exp %b", e.tag, tc, e.tc);
      end
      checks++;
      assert (busy === e.busy) else begin
        errors++;
        $error("[TB] FAIL %s busy got %b exp %b", e.tag, busy, e.busy);
      end
      checks++;
      assert (zero === e.zero) else begin
        errors++;
        $error("[TB] FAIL %s zero got %b exp %b", e.tag, zero, e.zero);
      end
    end
  endtask

  // One clock step: drive inputs, queue what the next edge should produce, check after it.
  task automatic applyStimulus(input logic ld, input logic [7:0] lv, input logic e,
                               input logic ar, input logic [7:0] exp_q,
                               input logic exp_tc, input logic exp_busy, input string tag);
    load        = ld;
    load_val    = lv;
    en          = e;
    auto_reload = ar;
    pushExpected(exp_q, exp_tc, exp_busy, tag);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    reset       = 1'b0;
    load        = 1'b0;
    load_val    = 8'd0;
    en          = 1'b0;
    auto_reload = 1'b0;
    #12;
    pushExpected(8'd0, 1'b0, 1'b0, "reset_state");
    checkOutput();
    reset = 1'b1;

    // Asynchronous reset in the middle of a count at 37
    applyStimulus(1'b1, 8'd40, 1'b0, 1'b0, 8'd40, 1'b0, 1'b1, "mid_load40");
    for (int i = 1; i <= 3; i++)
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 8'(40 - i), 1'b0, 1'b1, "mid_count");
    reset = 1'b0;
    #2;
    pushExpected(8'd0, 1'b0, 1'b0, "async_reset");
    checkOutput();
    #1;
    reset = 1'b1;

    // en alone after reset must not move the counter or wrap it
    for (int i = 0; i < 20; i++)
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, "idle_en");

    // One-shot from 5
    applyStimulus(1'b1, 8'd5, 1'b1, 1'b0, 8'd5, 1'b0, 1'b1, "os_load5");
    for (int i = 4; i >= 1; i--)
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 8'(i), 1'b0, 1'b1, "os_count");
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, "os_tc");
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, "os_stay0");

    // Periodic from 3: period of four enabled cycles
    applyStimulus(1'b1, 8'd3, 1'b1, 1'b1, 8'd3, 1'b0, 1'b1, "per_load3");
    for (int rep = 0; rep < 2; rep++) begin
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, 8'd2, 1'b0, 1'b1, "per_2");
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, 8'd1, 1'b0, 1'b1, "per_1");
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, 8'd0, 1'b1, 1'b1, "per_tc");
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, 8'd3, 1'b0, 1'b1, "per_reload");
    end

    // Pause, then a load that collides with the would-be terminal count
    applyStimulus(1'b1, 8'd4, 1'b1, 1'b0, 8'd4, 1'b0, 1'b1, "pause_load4");
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 8'd3, 1'b0, 1'b1, "pause_en1");
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 8'd3, 1'b0, 1'b1, "pause_en0a");
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 8'd3, 1'b0, 1'b1, "pause_en0b");
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 8'd2, 1'b0, 1'b1, "pause_resume");
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 8'd1, 1'b0, 1'b1, "pause_to1");
    applyStimulus(1'b1, 8'd9, 1'b1, 1'b0, 8'd9, 1'b0, 1'b1, "load_beats_tc");

    // Dropping periodic mode while parked at zero
    applyStimulus(1'b1, 8'd2, 1'b1, 1'b1, 8'd2, 1'b0, 1'b1, "drop_load2");
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, 8'd1, 1'b0, 1'b1, "drop_1");
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, 8'd0, 1'b1, 1'b1, "drop_tc");
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, "drop_hold0");
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, "drop_idle");

    // Load 0 from RUN goes straight to IDLE with no pulse
    applyStimulus(1'b1, 8'd5, 1'b0, 1'b0, 8'd5, 1'b0, 1'b1, "z_load5");
    applyStimulus(1'b1, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, "z_load0");
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, "z_after");

    // Full-scale 255 countdown
    applyStimulus(1'b1, 8'd255, 1'b1, 1'b0, 8'd255, 1'b0, 1'b1, "max_load");
    for (int i = 1; i <= 254; i++)
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 8'(255 - i), 1'b0, 1'b1, "max_count");
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, "max_tc");
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, "max_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
